// File: rtl/prod_accumulator.sv
// Frame accumulator for the multiplier's unsigned products: sums FRAME_LEN
// accepted products, then holds one result on a valid/ready output until taken.
module prod_accumulator #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int FRAME_LEN = 8,
    parameter int SATURATE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] value;
    logic             accept;

    // A carry out of the accumulator either clamps to all-ones or wraps.
    function automatic logic [ACC_W-1:0] clamp_sum(input logic [ACC_W:0] s);
        if (s[ACC_W] && (SATURATE != 0))
            clamp_sum = '1;
        else
            clamp_sum = s[ACC_W-1:0];
    endfunction

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign sum      = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_data};
    assign carry    = sum[ACC_W];
    assign value    = clamp_sum(sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // Abort wins over everything, including a pending result.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            out_data  <= value;
                            out_ovf   <= ovf | carry;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc <= value;
                            cnt <= cnt + 1'b1;
                            ovf <= ovf | carry;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
